tug_move_arbiter: RTL and testbench
===================================

Name: tug_move_arbiter

Overview:
Sits between the two debounced press-pulse sources (human key and computer player, each one-cycle pulses) and the tug-of-war playfield. It arbitrates the two players' presses, enforces a cooldown between moves and tracks rope position. It detects a win, keeps per-player scores and sequences the round-over hold and restart.

Parameters:
HALF, 4, lights per side; a win occurs when |pos| reaches HALF
COOLDOWN, 4, cycles in COOL after each granted move (>=1)
HOLD_CYCLES, 8, cycles in OVER before automatic restart (>=1)
POS_W, 4, signed width of pos; must hold -HALF..+HALF

Ports:
Clock  input  1  system clock, all state on posedge
Reset  input  1  synchronous, active-high
left_req  input  1  one-cycle press pulse, left player
right_req  input  1  one-cycle press pulse, right player
move_left  output  1  one-cycle pulse, rope moved one step left
move_right  output  1  one-cycle pulse, rope moved one step right
pos  output  POS_W  signed rope position; negative = left side
left_score  output  3  left wins, saturating at 7
right_score  output  3  right wins, saturating at 7
round_over  output  1  high throughout OVER
winner_left  output  1  valid while round_over; 1 = left won

Behaviour:
- Interface: clock Clock; reset Reset, synchronous, active-high.
- Reset values:
  - state = PLAY; pos = 0; left_score = right_score = 0.
  - move_left = move_right = round_over = winner_left = 0.
  - Pending flags, cooldown counter and hold counter = 0.
- Pending latches: one flag per side (pend_l, pend_r), one deep.
  - A req pulse sets its flag in states PLAY and COOL.
  - A req pulse is ignored in OVER.
  - A req while the flag is already set is dropped (no count).
  - If a req arrives on the same edge its flag is consumed, the set wins: the flag stays 1 and that press is queued.
- State PLAY, evaluated each edge:
  - Only pend_l set: clear pend_l; register move_left=1 for one cycle; pos <= pos-1; go to COOL.
  - Only pend_r set: mirror of the above (move_right, pos+1).
  - Both set: clear both; no move; pos unchanged; stay in PLAY (simultaneous presses cancel).
  - Neither set: idle.
- Latency: req high in cycle c -> pending set at end of c -> move pulse and new pos visible in cycle c+2, when state was PLAY and no conflict.
- State COOL:
  - Counter loads COOLDOWN-1 on entry; decrements each cycle; at 0 returns to PLAY.
  - No moves are granted in COOL.
  - Requests still latch.
- Win detection, on the grant edge:
  - If the new pos equals -HALF, go to OVER with winner_left=1 and left_score+1.
  - If the new pos equals +HALF, go to OVER with winner_left=0 and right_score+1.
  - Scores saturate at 7 and never wrap.
  - Win detection overrides COOL entry.
- State OVER:
  - round_over=1; pos is held at ±HALF.
  - Hold counter runs HOLD_CYCLES cycles.
  - On the final cycle: pos <= 0, both pending flags cleared, round_over <= 0, winner_left <= 0, go to PLAY.
  - Scores persist across rounds; only Reset clears them.
- move_left and move_right are never high in the same cycle; each pulse lasts exactly one cycle.
- Reset asserted mid-COOL or mid-OVER: all state returns to the reset values on that edge; no move pulse follows.

Optional Feature:
Macro TUG_RR_ARB_EN.
- Defined:
  - Both pending in PLAY no longer cancel.
  - A last_grant bit (reset 0 = right last) selects the side not most recently granted.
  - Only that side's flag is cleared; the other stays pending and is served after COOL.
  - last_grant is updated on every grant.
- Undefined: simultaneous pending presses cancel as described above; no last_grant register exists.

Test Plan:
- Reset, then left_req pulse in cycle 3 -> move_left=1 in cycle 5 only; pos=-1; state COOL for 4 cycles.
- After reset, left_req and right_req in the same cycle -> no move pulse; pos stays 0; both pending cleared. With TUG_RR_ARB_EN: move_left first, move_right after the cooldown, pos ends at 0.
- right_req pulses every cycle for 30 cycles -> move_right at most once per 5 cycles.
  - pos reaches +4, then round_over=1, winner_left=0, right_score=1.
  - round_over stays high 8 cycles, then pos=0 and PLAY.
- left_req pulse during COOL -> held pending; move_left issued on the first PLAY edge after cooldown.
- Eight left wins in a row -> left_score=7 after the 7th win and stays 7 after the 8th.
- Reset asserted in cycle 2 of OVER with right_score=3 -> next cycle: pos=0, scores=0, round_over=0, no move pulses.

Source files
------------

// File: rtl/tug_move_arbiter.sv
// tug_move_arbiter
//
// Purpose: arbitrates the two players' debounced press pulses for the
// tug-of-war playfield. It enforces a cooldown after every granted move,
// tracks the signed rope position, detects a win, keeps per-player
// saturating scores and sequences the round-over hold and automatic restart.
//
// Optional build macro: TUG_RR_ARB_EN
//   When defined, simultaneous pending presses are served alternately,
//   starting with the side that was not granted most recently. When
//   undefined, simultaneous pending presses cancel each other.
//
// Ports:
//   Clock        in   system clock, all state on posedge
//   Reset        in   synchronous, active-high
//   left_req     in   one-cycle press pulse, left player
//   right_req    in   one-cycle press pulse, right player
//   move_left    out  one-cycle pulse, rope moved one step left
//   move_right   out  one-cycle pulse, rope moved one step right
//   pos          out  signed rope position, negative = left side
//   left_score   out  left wins, saturating at 7
//   right_score  out  right wins, saturating at 7
//   round_over   out  high throughout the round-over hold
//   winner_left  out  valid while round_over, 1 = left won
module tug_move_arbiter #(
    parameter int HALF        = 4,
    parameter int COOLDOWN    = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int POS_W       = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    left_req,
    input  logic                    right_req,
    output logic                    move_left,
    output logic                    move_right,
    output logic signed [POS_W-1:0] pos,
    output logic [2:0]              left_score,
    output logic [2:0]              right_score,
    output logic                    round_over,
    output logic                    winner_left
);

    localparam logic [1:0] ST_PLAY = 2'd0;
    localparam logic [1:0] ST_COOL = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    localparam int COOL_W = $clog2(COOLDOWN + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic signed [POS_W-1:0] POS_WIN_LEFT  = POS_W'(-HALF);
    localparam logic signed [POS_W-1:0] POS_WIN_RIGHT = POS_W'(HALF);
    localparam logic signed [POS_W-1:0] POS_ONE       = POS_W'(1);

    // Score increment that sticks at the top value instead of wrapping.
    function automatic logic [2:0] sat_inc(input logic [2:0] score);
        if (score == 3'd7) begin
            sat_inc = score;
        end else begin
            sat_inc = score + 3'd1;
        end
    endfunction

    logic [1:0]        state_r, state_s;
    logic              pend_l_r, pend_l_s;
    logic              pend_r_r, pend_r_s;
    logic [COOL_W-1:0] cool_cnt_r, cool_cnt_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
    logic signed [POS_W-1:0] pos_s;
    logic [2:0]        left_score_s, right_score_s;
    logic              move_left_s, move_right_s;
    logic              round_over_s, winner_left_s;
    logic              grant_l_s, grant_r_s;
    logic signed [POS_W-1:0] new_pos_s;
`ifdef TUG_RR_ARB_EN
    // 1 = left was granted most recently, 0 = right was
    logic              last_grant_r, last_grant_s;
`endif

    // Next-state logic: arbitration, cooldown/hold sequencing and win detection.
    always_comb begin
        state_s       = state_r;
        pend_l_s      = pend_l_r;
        pend_r_s      = pend_r_r;
        cool_cnt_s    = cool_cnt_r;
        hold_cnt_s    = hold_cnt_r;
        pos_s         = pos;
        left_score_s  = left_score;
        right_score_s = right_score;
        move_left_s   = 1'b0;
        move_right_s  = 1'b0;
        round_over_s  = round_over;
        winner_left_s = winner_left;
        grant_l_s     = 1'b0;
        grant_r_s     = 1'b0;
        new_pos_s     = pos;
`ifdef TUG_RR_ARB_EN
        last_grant_s  = last_grant_r;
`endif

        case (state_r)
            ST_PLAY: begin
                if (pend_l_r && pend_r_r) begin
`ifdef TUG_RR_ARB_EN
                    // Serve the side that did not win the previous grant.
                    grant_l_s = ~last_grant_r;
                    grant_r_s = last_grant_r;
`else
                    // Simultaneous presses cancel each other.
                    pend_l_s = 1'b0;
                    pend_r_s = 1'b0;
`endif
                end else begin
                    grant_l_s = pend_l_r;
                    grant_r_s = pend_r_r;
                end

                if (grant_l_s || grant_r_s) begin
                    if (grant_l_s) begin
                        pend_l_s    = 1'b0;
                        move_left_s = 1'b1;
                        new_pos_s   = pos - POS_ONE;
                    end else begin
                        pend_r_s     = 1'b0;
                        move_right_s = 1'b1;
                        new_pos_s    = pos + POS_ONE;
                    end
`ifdef TUG_RR_ARB_EN
                    last_grant_s = grant_l_s;
`endif
                    pos_s = new_pos_s;
                    // A winning step goes straight to the hold, skipping cooldown.
                    if (new_pos_s == POS_WIN_LEFT) begin
                        state_s       = ST_OVER;
                        hold_cnt_s    = HOLD_W'(HOLD_CYCLES - 1);
                        round_over_s  = 1'b1;
                        winner_left_s = 1'b1;
                        left_score_s  = sat_inc(left_score);
                    end else if (new_pos_s == POS_WIN_RIGHT) begin
                        state_s       = ST_OVER;
                        hold_cnt_s    = HOLD_W'(HOLD_CYCLES - 1);
                        round_over_s  = 1'b1;
                        winner_left_s = 1'b0;
                        right_score_s = sat_inc(right_score);
                    end else begin
                        state_s    = ST_COOL;
                        cool_cnt_s = COOL_W'(COOLDOWN - 1);
                    end
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_COOL: begin
                if (cool_cnt_r == '0) begin
                    state_s = ST_PLAY;
                end else begin
                    cool_cnt_s = cool_cnt_r - COOL_W'(1);
                end
            end
            ST_OVER: begin
                if (hold_cnt_r == '0) begin
                    state_s       = ST_PLAY;
                    pos_s         = '0;
                    pend_l_s      = 1'b0;
                    pend_r_s      = 1'b0;
                    round_over_s  = 1'b0;
                    winner_left_s = 1'b0;
                end else begin
                    hold_cnt_s = hold_cnt_r - HOLD_W'(1);
                end
            end
            default: begin
                state_s = ST_PLAY;
            end
        endcase

        // A new press outranks a same-edge consume, so it is applied last.
        if (state_r != ST_OVER) begin
            pend_l_s = pend_l_s | left_req;
            pend_r_s = pend_r_s | right_req;
        end else begin
            pend_l_s = pend_l_s;
            pend_r_s = pend_r_s;
        end
    end

    // State and registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r     <= ST_PLAY;
            pend_l_r    <= 1'b0;
            pend_r_r    <= 1'b0;
            cool_cnt_r  <= '0;
            hold_cnt_r  <= '0;
            pos         <= '0;
            left_score  <= 3'd0;
            right_score <= 3'd0;
            move_left   <= 1'b0;
            move_right  <= 1'b0;
            round_over  <= 1'b0;
            winner_left <= 1'b0;
        end else begin
            state_r     <= state_s;
            pend_l_r    <= pend_l_s;
            pend_r_r    <= pend_r_s;
            cool_cnt_r  <= cool_cnt_s;
            hold_cnt_r  <= hold_cnt_s;
            pos         <= pos_s;
            left_score  <= left_score_s;
            right_score <= right_score_s;
            move_left   <= move_left_s;
            move_right  <= move_right_s;
            round_over  <= round_over_s;
            winner_left <= winner_left_s;
        end
    end

`ifdef TUG_RR_ARB_EN
    // Round-robin history bit.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            last_grant_r <= 1'b0;
        end else begin
            last_grant_r <= last_grant_s;
        end
    end
`endif

endmodule

// File: tb/tb_tug_move_arbiter.sv
// Testbench for tug_move_arbiter: directed scenarios plus random presses,
// scoreboarded against a cycle-level reference model of the game rules.
module tb_tug_move_arbiter;

    localparam int HALF        = 4;
    localparam int COOLDOWN    = 4;
    localparam int HOLD_CYCLES = 8;
    localparam int POS_W       = 4;

    logic                    Clock;
    logic                    Reset;
    logic                    left_req;
    logic                    right_req;
    logic                    move_left;
    logic                    move_right;
    logic signed [POS_W-1:0] pos;
    logic [2:0]              left_score;
    logic [2:0]              right_score;
    logic                    round_over;
    logic                    winner_left;

    tug_move_arbiter #(
        .HALF(HALF), .COOLDOWN(COOLDOWN), .HOLD_CYCLES(HOLD_CYCLES), .POS_W(POS_W)
    ) dut (
        .Clock(Clock), .Reset(Reset), .left_req(left_req), .right_req(right_req),
        .move_left(move_left), .move_right(move_right), .pos(pos),
        .left_score(left_score), .right_score(right_score),
        .round_over(round_over), .winner_left(winner_left)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected outputs after each edge: {ml, mr, pos, ls, rs, ro, wl}
    logic [13:0] exp_q[$];

    // Reference model: game phase plus remaining-cycle counts.
    int m_phase;        // 0 = playing, 1 = cooling down, 2 = round over
    int m_cool_left;    // cooldown cycles still to spend
    int m_hold_left;    // hold cycles still to spend
    int m_pos, m_ls, m_rs;
    bit m_pl, m_pr, m_ml, m_mr, m_ro, m_wl;
    bit m_left_last;

    function automatic logic [13:0] pack_exp();
        logic [3:0] p;
        p = 4'(m_pos);
        return {m_ml, m_mr, p, 3'(m_ls), 3'(m_rs), m_ro, m_wl};
    endfunction

    task automatic model_step(input bit rst, input bit lr, input bit rr);
        bit gl, gr, was_over;
        gl = 1'b0; gr = 1'b0;
        m_ml = 1'b0; m_mr = 1'b0;
        if (rst) begin
            m_phase = 0; m_cool_left = 0; m_hold_left = 0;
            m_pos = 0; m_ls = 0; m_rs = 0;
            m_pl = 1'b0; m_pr = 1'b0; m_ro = 1'b0; m_wl = 1'b0;
            m_left_last = 1'b0;
            return;
        end
        was_over = (m_phase == 2);
        if (m_phase == 0) begin
            if (m_pl && m_pr) begin
`ifdef TUG_RR_ARB_EN
                gl = !m_left_last; gr = m_left_last;
`else
                m_pl = 1'b0; m_pr = 1'b0;
`endif
            end else begin
                gl = m_pl; gr = m_pr;
            end
            if (gl || gr) begin
                if (gl) begin m_pl = 1'b0; m_ml = 1'b1; m_pos = m_pos - 1; end
                else    begin m_pr = 1'b0; m_mr = 1'b1; m_pos = m_pos + 1; end
                m_left_last = gl;
                if (m_pos == -HALF || m_pos == HALF) begin
                    m_phase = 2; m_hold_left = HOLD_CYCLES; m_ro = 1'b1;
                    m_wl = (m_pos < 0);
                    if (m_pos < 0) m_ls = (m_ls < 7) ? m_ls + 1 : 7;
                    else           m_rs = (m_rs < 7) ? m_rs + 1 : 7;
                end else begin
                    m_phase = 1; m_cool_left = COOLDOWN;
                end
            end
        end else if (m_phase == 1) begin
            m_cool_left--;
            if (m_cool_left == 0) m_phase = 0;
        end else begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                m_phase = 0; m_pos = 0; m_pl = 1'b0; m_pr = 1'b0;
                m_ro = 1'b0; m_wl = 1'b0;
            end
        end
        if (!was_over) begin
            if (lr) m_pl = 1'b1;
            if (rr) m_pr = 1'b1;
        end
    endtask

    // One clock of stimulus: drive on the falling edge, predict the next edge.
    task automatic cycle(input bit rst, input bit lr, input bit rr);
        @(negedge Clock);
        Reset = rst; left_req = lr; right_req = rr;
        model_step(rst, lr, rr);
        exp_q.push_back(pack_exp());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_val(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Monitor: compares every presented cycle against the scoreboard head.
    initial begin
        logic [13:0] e, a;
        forever begin
            @(posedge Clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {move_left, move_right, pos, left_score, right_score, round_over, winner_left};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: actual ml=%b mr=%b pos=%0d ls=%0d rs=%0d ro=%b wl=%b required ml=%b mr=%b pos=%0d ls=%0d rs=%0d ro=%b wl=%b",
                             $time, a[13], a[12], $signed(a[11:8]), a[7:5], a[4:2], a[1], a[0],
                             e[13], e[12], $signed(e[11:8]), e[7:5], e[4:2], e[1], e[0]);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int budget;
        Reset = 1'b1; left_req = 1'b0; right_req = 1'b0;

        // Reset, then a single left press in cycle 3.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        idle(12);

        // Simultaneous presses from a fresh reset.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        idle(14);
        @(posedge Clock); #2;
        check_val("pos_after_simultaneous", int'(pos), 0);

        // Right player hammers every cycle for 30 cycles, then hold drains.
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 1'b1);
        idle(15);
        @(posedge Clock); #2;
        check_val("right_score_after_win", int'(right_score), 1);

        // Left press during cooldown is held and served afterwards.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        idle(2);
        cycle(1'b0, 1'b1, 1'b0);
        idle(15);

        // Many consecutive left wins: score saturates at 7.
        for (int i = 0; i < 330; i++) cycle(1'b0, 1'b1, 1'b0);
        idle(12);
        @(posedge Clock); #2;
        check_val("left_score_saturated", int'(left_score), 7);

        // Reset in the second cycle of a hold with right_score = 3.
        cycle(1'b1, 1'b0, 1'b0);
        budget = 0;
        while (!(m_phase == 2 && m_rs == 3) && budget < 400) begin
            cycle(1'b0, 1'b0, 1'b1);
            budget++;
        end
        check_val("reach_third_right_win", budget < 400 ? 1 : 0, 1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        @(posedge Clock); #2;
        check_val("right_score_after_reset", int'(right_score), 0);
        check_val("round_over_after_reset", int'(round_over), 0);
        idle(3);

        // Random presses with occasional resets.
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(99) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0);
        end
        idle(20);

        @(posedge Clock); #3;
        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
